// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encodings, line-mux selects and parity types for the UART TX controller
package uart_tx_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_DATA  = 2'b01;
    localparam logic [1:0] MUX_PAR   = 2'b10;
    localparam logic [1:0] MUX_IDLE  = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_ctrl_parity.sv
// uart_parity_calc: combinational parity fold of a data word, even or odd
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : ^data;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART TX frame sequencer (start, data, parity, stop); macro UART_TX_TWO_STOP_EN adds an optional second stop bit
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WDOG_CYC   = DATA_WIDTH + 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  STOP2,
`endif
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic [1:0]            mux_sel,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  ERR
);
    localparam int WW = $clog2(WDOG_CYC + 1);

    logic [2:0]            state, next_state;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_typ_q, par_bit, tx_next, load, wd_hit, wd_abort;
    logic [WW-1:0]         wd_cnt;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop2_q;
`endif

    // parity derives from the byte and type latched at acceptance, so it is stable for the whole frame
    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    assign wd_hit   = (wd_cnt == WW'(WDOG_CYC - 1));
    assign wd_abort = (state == ST_DATA) && !ser_done && wd_hit;
    assign load     = (next_state == ST_START);
    assign ser_en   = (state == ST_DATA);
    assign BUSY     = (state != ST_IDLE);
    assign mux_sel  = (state == ST_START)  ? MUX_START :
                      (state == ST_DATA)   ? MUX_DATA  :
                      (state == ST_PARITY) ? MUX_PAR   : MUX_IDLE;
    assign tx_next  = (next_state == ST_START)  ? 1'b0     :
                      (next_state == ST_DATA)   ? ser_data :
                      (next_state == ST_PARITY) ? par_bit  : 1'b1;

    // frame sequencing; ser_done beats a coincident watchdog expiry
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:   next_state = DATA_VALID ? ST_START : ST_IDLE;
            ST_START:  next_state = ST_DATA;
            ST_DATA:   next_state = ser_done ? (par_en_q ? ST_PARITY : ST_STOP) : (wd_hit ? ST_STOP : ST_DATA);
            ST_PARITY: next_state = ST_STOP;
`ifdef UART_TX_TWO_STOP_EN
            ST_STOP:   next_state = stop2_q ? ST_STOP2 : (DATA_VALID ? ST_START : ST_IDLE);
            ST_STOP2:  next_state = DATA_VALID ? ST_START : ST_IDLE;
`else
            ST_STOP:   next_state = DATA_VALID ? ST_START : ST_IDLE;
`endif
            default:   next_state = ST_IDLE;
        endcase
    end

    // state, registered line, watchdog, sticky error and per-frame latches
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            TX_OUT    <= 1'b1;
            ERR       <= 1'b0;
            wd_cnt    <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= 1'b0;
`endif
        end else begin
            state  <= next_state;
            TX_OUT <= tx_next;
            wd_cnt <= (state == ST_DATA) ? wd_cnt + 1'b1 : '0;
            if (wd_abort)
                ERR <= 1'b1;
            if (load) begin
                data_q    <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
`ifdef UART_TX_TWO_STOP_EN
                stop2_q   <= STOP2;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized scoreboard bench for uart_tx_ctrl (honours UART_TX_TWO_STOP_EN)
module tb_uart_tx_ctrl;
    localparam int W  = 8;
    localparam int WD = W + 2;
`ifdef UART_TX_TWO_STOP_EN
    localparam bit HAS_S2 = 1'b1;
`else
    localparam bit HAS_S2 = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    logic       STOP2 = 1'b0;
`endif
    logic       ser_data, ser_done, ser_en, TX_OUT, BUSY, ERR;
    logic [1:0] mux_sel;

    // expected per-cycle {TX_OUT, ser_en, mux_sel, ERR} while the frame is on the line
    logic [4:0] q[$];
    logic [4:0] e_mon;
    int         checks = 0, failures = 0;
    logic [7:0] ser_byte = 8'h00;
    logic       no_done = 1'b0;
    logic       err_sticky = 1'b0;
    int         cnt = 0;
    int         idx;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
`ifdef UART_TX_TWO_STOP_EN
        .STOP2      (STOP2),
`endif
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    // serializer model: bit 0 ready before enable, next bit presented each enabled cycle, done on the last
    always @(posedge CLK) cnt <= ser_en ? cnt + 1 : 0;
    assign idx      = ser_en ? cnt + 1 : 0;
    assign ser_data = (idx < W) ? ser_byte[idx[2:0]] : 1'b1;
    assign ser_done = ser_en && (cnt == W - 1) && !no_done;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic tx, input logic en, input logic [1:0] m, input logic er);
        q.push_back({tx, en, m, er});
    endtask

    // reference frame: start, LSB-first data, optional parity or watchdog overrun, stop bit(s)
    task automatic expect_frame(input logic [7:0] b, input logic pe, input logic pt, input logic s2, input logic wd);
        push(1'b0, 1'b0, 2'b00, err_sticky);
        for (int i = 0; i < W; i++) push(b[i], 1'b1, 2'b01, err_sticky);
        if (wd) begin
            for (int i = W; i < WD; i++) push(1'b1, 1'b1, 2'b01, err_sticky);
            err_sticky = 1'b1;
        end else if (pe)
            push(($countones(b) % 2 == 1) ^ pt, 1'b0, 2'b10, err_sticky);
        push(1'b1, 1'b0, 2'b11, err_sticky);
        if (s2) push(1'b1, 1'b0, 2'b11, err_sticky);
    endtask

    // call at #1 after an edge where the DUT is idle or in its final stop cycle
    task automatic frame(input logic [7:0] b, input logic pe, input logic pt, input logic s2, input logic wd, input logic b2b);
        int len;
        P_DATA = b; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        STOP2 = s2;
`endif
        @(posedge CLK); #1;
        expect_frame(b, pe, pt, s2, wd);
        ser_byte = b; no_done = wd;
        DATA_VALID = b2b; P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
`ifdef UART_TX_TWO_STOP_EN
        STOP2 = 1'($urandom);
`endif
        len = (wd ? 2 + WD : 2 + W + int'(pe)) + int'(s2);
        repeat (len - 1) @(posedge CLK);
        #1;
        if (!b2b) begin
            DATA_VALID = 1'b0;
            repeat (1 + $urandom_range(0, 2)) @(posedge CLK);
            #1;
        end
    endtask

    // monitor: every busy cycle consumes one expected line cycle
    always @(negedge CLK) begin
        if (!RST) begin
            if (BUSY) begin
                if (q.size() == 0)
                    check("unexpected_busy", 8'(BUSY), 8'd0);
                else begin
                    e_mon = q.pop_front();
                    check("frame_cycle", {3'b0, TX_OUT, ser_en, mux_sel, ERR}, {3'b0, e_mon});
                end
            end else if (q.size() != 0)
                check("busy_dropped", 8'(BUSY), 8'd1);
            else
                check("idle", {3'b0, TX_OUT, ser_en, mux_sel, ERR}, {3'b0, 1'b1, 1'b0, 2'b11, err_sticky});
        end
    end

    initial begin
        @(posedge CLK); #1;
        check("reset_state", {2'b0, BUSY, TX_OUT, ser_en, mux_sel, ERR}, {2'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0});
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        if (HAS_S2) begin
            frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("err_after_wdog", 8'(ERR), 8'd1);
        frame(8'h17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("err_sticky", 8'(ERR), 8'd1);
        P_DATA = 8'h6B; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        STOP2 = 1'b0;
`endif
        @(posedge CLK); #1;
        expect_frame(8'h6B, 1'b0, 1'b0, 1'b0, 1'b0);
        ser_byte = 8'h6B; no_done = 1'b0; DATA_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        check("pre_reset_ser_en", 8'(ser_en), 8'd1);
        RST = 1'b1;
        q.delete();
        err_sticky = 1'b0;
        #1;
        check("reset_mid_frame", {2'b0, BUSY, TX_OUT, ser_en, mux_sel, ERR}, {2'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0});
        @(posedge CLK); #3;
        RST = 1'b0;
        @(posedge CLK); #1;
        frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (40)
            frame(8'($urandom), 1'($urandom), 1'($urandom), HAS_S2 & 1'($urandom), $urandom_range(0, 9) == 0, 1'($urandom));
        frame(8'h4E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        check("scoreboard_drained", 8'(q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
